cam_pixel_capture: RTL and testbench

- Writer-side front end of the camera pixel path. Assembles the camera's 8-bit byte stream (two bytes per pixel, RGB565) into 16-bit RGB565 words.
- Tags each word with X/Y coordinates and a linear frame-buffer address, then emits it with a one-cycle valid strobe.
- Output feeds the RGB565-to-RGB332 downsampler and the frame-buffer write port.

---
 rtl/cam_pkg.sv | 28 ++
 rtl/cam_sync_edge.sv | 34 +++
 rtl/cam_pixel_capture.sv | 123 ++++++++++++
 tb/tb_cam_pixel_capture.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared camera-path constants: frame geometry, FSM encoding and byte order.
package cam_pkg;

  localparam int unsigned CAM_IMG_WIDTH  = 176;
  localparam int unsigned CAM_IMG_HEIGHT = 144;
  localparam int unsigned CAM_ADDR_W     = 15;
  localparam int unsigned CAM_BYTE_W     = 8;
  localparam int unsigned CAM_PIX_W      = 16;
  localparam int unsigned CAM_XY_W       = 8;

  // Capture FSM encoding
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ARMED = 1'b1;

  // Byte phase within a pixel
  localparam logic PHASE_HI = 1'b0;
  localparam logic PHASE_LO = 1'b1;

  // The sensor sends the high byte of each RGB565 word first
  localparam bit HI_BYTE_FIRST = 1'b1;

  // Join the two sensor bytes of one pixel in the configured order
  function automatic logic [CAM_PIX_W-1:0] pack_rgb565(input logic [CAM_BYTE_W-1:0] first,
                                                       input logic [CAM_BYTE_W-1:0] second);
    return HI_BYTE_FIRST ? {first, second} : {second, first};
  endfunction

endpackage

// File: rtl/cam_sync_edge.sv
// Registers VSYNC/HREF once and produces the edge pulses used by the capture FSM.
module cam_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic vsync,
  input  logic href,
  output logic vsync_fall_c,
  output logic vsync_rise_c,
  output logic href_fall_c
);

  logic vsync_prev;
  logic href_prev;
  logic primed;

  // History registers; primed blocks the reset value of vsync_prev from faking a fall
  // when reset is released in the middle of an active frame
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_prev <= 1'b1;
      href_prev  <= 1'b0;
      primed     <= 1'b0;
    end else begin
      vsync_prev <= vsync;
      href_prev  <= href;
      primed     <= 1'b1;
    end
  end

  assign vsync_fall_c = primed & vsync_prev & ~vsync;
  assign vsync_rise_c = ~vsync_prev & vsync;
  assign href_fall_c  = href_prev & ~href;

endmodule

// File: rtl/cam_pixel_capture.sv
// Assembles the camera byte stream into RGB565 pixels tagged with X/Y and a linear address.
module cam_pixel_capture
  import cam_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = CAM_IMG_WIDTH,
  parameter int unsigned IMG_HEIGHT = CAM_IMG_HEIGHT,
  parameter int unsigned ADDR_W     = CAM_ADDR_W
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  VSYNC,
  input  logic                  HREF,
  input  logic [CAM_BYTE_W-1:0] DATA,
  output logic [CAM_PIX_W-1:0]  RGB565,
  output logic                  PIXEL_VALID,
  output logic [CAM_XY_W-1:0]   X_ADDR,
  output logic [CAM_XY_W-1:0]   Y_ADDR,
  output logic [ADDR_W-1:0]     WRITE_ADDR,
  output logic                  FRAME_DONE
);

  localparam logic [CAM_XY_W-1:0] XMAX   = CAM_XY_W'(IMG_WIDTH);
  localparam logic [CAM_XY_W-1:0] YMAX   = CAM_XY_W'(IMG_HEIGHT);
  localparam logic [ADDR_W-1:0]   W_STEP = ADDR_W'(IMG_WIDTH);
  localparam logic [ADDR_W-1:0]   A_ONE  = ADDR_W'(1);

  logic [0:0]            state_q;
  logic [0:0]            state_d;
  logic                  vsync_fall_c;
  logic                  vsync_rise_c;
  logic                  href_fall_c;
  logic [CAM_XY_W-1:0]   x;
  logic [CAM_XY_W-1:0]   y;
  logic                  phase;
  logic [CAM_BYTE_W-1:0] hi_byte;
  logic [ADDR_W-1:0]     pix_addr;
  logic [ADDR_W-1:0]     line_base;

  cam_sync_edge u_sync_edge (
    .clk          (CLK),
    .rst          (RESET),
    .vsync        (VSYNC),
    .href         (HREF),
    .vsync_fall_c (vsync_fall_c),
    .vsync_rise_c (vsync_rise_c),
    .href_fall_c  (href_fall_c)
  );

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state: arm on VSYNC fall, disarm on VSYNC rise
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (vsync_fall_c) state_d = ST_ARMED;
      ST_ARMED: if (vsync_rise_c) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Capture datapath: byte pairing, coordinate counters, running address, output registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      x           <= '0;
      y           <= '0;
      phase       <= PHASE_HI;
      hi_byte     <= '0;
      pix_addr    <= '0;
      line_base   <= '0;
      RGB565      <= '0;
      PIXEL_VALID <= 1'b0;
      X_ADDR      <= '0;
      Y_ADDR      <= '0;
      WRITE_ADDR  <= '0;
      FRAME_DONE  <= 1'b0;
    end else begin
      PIXEL_VALID <= 1'b0;
      FRAME_DONE  <= 1'b0;
      if (state_q == ST_IDLE) begin
        if (vsync_fall_c) begin
          x         <= '0;
          y         <= '0;
          phase     <= PHASE_HI;
          pix_addr  <= '0;
          line_base <= '0;
        end
      end else if (vsync_rise_c) begin
        // Frame end wins over a coincident line end; a pending half pixel is dropped
        FRAME_DONE <= 1'b1;
        phase      <= PHASE_HI;
      end else if (href_fall_c) begin
        x     <= '0;
        phase <= PHASE_HI;
        if ((x != '0) && (y < YMAX)) begin
          y         <= y + CAM_XY_W'(1);
          line_base <= line_base + W_STEP;
          pix_addr  <= line_base + W_STEP;
        end
      end else if (HREF && !VSYNC) begin
        if (phase == PHASE_HI) begin
          hi_byte <= DATA;
          phase   <= PHASE_LO;
        end else begin
          if ((x < XMAX) && (y < YMAX)) begin
            RGB565      <= pack_rgb565(hi_byte, DATA);
            X_ADDR      <= x;
            Y_ADDR      <= y;
            WRITE_ADDR  <= pix_addr;
            PIXEL_VALID <= 1'b1;
            pix_addr    <= pix_addr + A_ONE;
          end
          if (x < XMAX) x <= x + CAM_XY_W'(1);
          phase <= PHASE_HI;
        end
      end
    end
  end

endmodule

// File: tb/tb_cam_pixel_capture.sv
// Directed bench for cam_pixel_capture: vector table plus frame, overflow and reset sequences.
module tb_cam_pixel_capture;

  localparam int unsigned W  = 176;
  localparam int unsigned H  = 144;
  localparam int unsigned AW = 15;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          VSYNC;
  logic          HREF;
  logic [7:0]    DATA;
  logic [15:0]   RGB565;
  logic          PIXEL_VALID;
  logic [7:0]    X_ADDR;
  logic [7:0]    Y_ADDR;
  logic [AW-1:0] WRITE_ADDR;
  logic          FRAME_DONE;

  cam_pixel_capture #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .ADDR_W     (AW)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .VSYNC       (VSYNC),
    .HREF        (HREF),
    .DATA        (DATA),
    .RGB565      (RGB565),
    .PIXEL_VALID (PIXEL_VALID),
    .X_ADDR      (X_ADDR),
    .Y_ADDR      (Y_ADDR),
    .WRITE_ADDR  (WRITE_ADDR),
    .FRAME_DONE  (FRAME_DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic          vs;
    logic          h;
    logic [7:0]    d;
    logic          ev;
    logic [15:0]   rgb;
    logic [7:0]    x;
    logic [7:0]    y;
    logic [AW-1:0] a;
    logic          done;
  } vec_t;

  typedef struct {
    logic [15:0]   rgb;
    logic [7:0]    x;
    logic [7:0]    y;
    logic [AW-1:0] a;
  } pix_t;

  vec_t vecs[$];
  pix_t exp_q[$];

  int checks     = 0;
  int errors     = 0;
  int strobe_cnt = 0;
  int done_cnt   = 0;
  bit sb_en      = 1'b0;
  bit prev_valid = 1'b0;
  logic [7:0]    last_x = '0;
  logic [7:0]    last_y = '0;
  logic [AW-1:0] last_a = '0;
  logic [7:0]    dbyte  = '0;

  function automatic void add(logic vs, logic h, logic [7:0] d, logic ev, logic [15:0] rgb,
                              logic [7:0] x, logic [7:0] y, logic [AW-1:0] a, logic done);
    vec_t v;
    v.vs = vs; v.h = h; v.d = d; v.ev = ev; v.rgb = rgb;
    v.x = x; v.y = y; v.a = a; v.done = done;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic drive(input logic vs, input logic h, input logic [7:0] d);
    @(negedge CLK);
    VSYNC = vs;
    HREF  = h;
    DATA  = d;
  endtask

  task automatic push_pix(input logic [15:0] rgb, input int x, input int y);
    pix_t p;
    p.rgb = rgb;
    p.x   = 8'(x);
    p.y   = 8'(y);
    p.a   = AW'(y * int'(W) + x);
    exp_q.push_back(p);
  endtask

  // One line of npx incrementing-byte pixels followed by a single HREF-low cycle
  task automatic send_line(input int npx, input int row);
    logic [7:0] hi_b;
    logic [7:0] lo_b;
    for (int p = 0; p < npx; p++) begin
      hi_b  = dbyte;
      lo_b  = dbyte + 8'd1;
      dbyte = dbyte + 8'd2;
      drive(1'b0, 1'b1, hi_b);
      if (p < int'(W) && row < int'(H)) push_pix({hi_b, lo_b}, p, row);
      drive(1'b0, 1'b1, lo_b);
    end
    drive(1'b0, 1'b0, 8'h00);
  endtask

  // Strobe monitor: spacing, address law, bounds and optional in-order scoreboard
  always @(negedge CLK) begin : mon
    pix_t e;
    if (PIXEL_VALID) begin
      strobe_cnt++;
      last_x = X_ADDR;
      last_y = Y_ADDR;
      last_a = WRITE_ADDR;
      checks++;
      if (prev_valid) begin
        errors++;
        $display("FAIL strobe_spacing: valid high on consecutive cycles at x=%0d y=%0d", X_ADDR, Y_ADDR);
      end
      checks++;
      if (int'(X_ADDR) >= int'(W) || int'(Y_ADDR) >= int'(H) ||
          int'(WRITE_ADDR) != int'(Y_ADDR) * int'(W) + int'(X_ADDR)) begin
        errors++;
        $display("FAIL addr_law: got x=%0d y=%0d addr=%0d required addr=%0d within %0dx%0d",
                 X_ADDR, Y_ADDR, WRITE_ADDR, int'(Y_ADDR) * int'(W) + int'(X_ADDR), W, H);
      end
      if (sb_en) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard: unexpected strobe rgb=%h x=%0d y=%0d addr=%0d",
                   RGB565, X_ADDR, Y_ADDR, WRITE_ADDR);
        end else begin
          e = exp_q.pop_front();
          if (RGB565 !== e.rgb || X_ADDR !== e.x || Y_ADDR !== e.y || WRITE_ADDR !== e.a) begin
            errors++;
            $display("FAIL scoreboard: got rgb=%h x=%0d y=%0d addr=%0d required rgb=%h x=%0d y=%0d addr=%0d",
                     RGB565, X_ADDR, Y_ADDR, WRITE_ADDR, e.rgb, e.x, e.y, e.a);
          end
        end
      end
    end
    prev_valid = PIXEL_VALID;
    if (FRAME_DONE) done_cnt++;
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin : main
    int s0;
    int d0;

    // Table: each row is one cycle of inputs and the outputs visible just after that edge
    add(1,1,8'hAA, 0,16'h0000,8'd0,8'd0,15'd0,   0); // bytes before arming
    add(1,1,8'hBB, 0,16'h0000,8'd0,8'd0,15'd0,   0);
    add(1,0,8'h00, 0,16'h0000,8'd0,8'd0,15'd0,   0);
    add(0,0,8'h00, 0,16'h0000,8'd0,8'd0,15'd0,   0); // VSYNC fall -> armed
    add(0,1,8'hF8, 0,16'h0000,8'd0,8'd0,15'd0,   0);
    add(0,1,8'h00, 1,16'hF800,8'd0,8'd0,15'd0,   0);
    add(0,1,8'h07, 0,16'hF800,8'd0,8'd0,15'd0,   0);
    add(0,1,8'hE0, 1,16'h07E0,8'd1,8'd0,15'd1,   0);
    add(0,0,8'h00, 0,16'h07E0,8'd1,8'd0,15'd1,   0); // line end
    add(1,0,8'h00, 0,16'h07E0,8'd1,8'd0,15'd1,   1); // frame end
    add(1,0,8'h00, 0,16'h07E0,8'd1,8'd0,15'd1,   0);
    add(0,0,8'h00, 0,16'h07E0,8'd1,8'd0,15'd1,   0); // re-arm
    add(0,1,8'h11, 0,16'h07E0,8'd1,8'd0,15'd1,   0); // odd 7-byte line
    add(0,1,8'h22, 1,16'h1122,8'd0,8'd0,15'd0,   0);
    add(0,1,8'h33, 0,16'h1122,8'd0,8'd0,15'd0,   0);
    add(0,1,8'h44, 1,16'h3344,8'd1,8'd0,15'd1,   0);
    add(0,1,8'h55, 0,16'h3344,8'd1,8'd0,15'd1,   0);
    add(0,1,8'h66, 1,16'h5566,8'd2,8'd0,15'd2,   0);
    add(0,1,8'h77, 0,16'h5566,8'd2,8'd0,15'd2,   0);
    add(0,0,8'h00, 0,16'h5566,8'd2,8'd0,15'd2,   0); // trailing byte dropped
    add(0,1,8'h88, 0,16'h5566,8'd2,8'd0,15'd2,   0);
    add(0,1,8'h99, 1,16'h8899,8'd0,8'd1,15'd176, 0);
    add(0,1,8'hAB, 0,16'h8899,8'd0,8'd1,15'd176, 0); // half pixel pending
    add(1,0,8'h00, 0,16'h8899,8'd0,8'd1,15'd176, 1); // HREF fall + VSYNC rise together
    add(1,0,8'h00, 0,16'h8899,8'd0,8'd1,15'd176, 0);
    add(1,1,8'hCD, 0,16'h8899,8'd0,8'd1,15'd176, 0); // idle again
    add(0,0,8'h00, 0,16'h8899,8'd0,8'd1,15'd176, 0); // re-arm
    add(0,1,8'hEE, 0,16'h8899,8'd0,8'd1,15'd176, 0);
    add(1,1,8'hFF, 0,16'h8899,8'd0,8'd1,15'd176, 1); // VSYNC rise, half pixel pending
    add(1,0,8'h00, 0,16'h8899,8'd0,8'd1,15'd176, 0);

    RESET = 1'b1;
    VSYNC = 1'b1;
    HREF  = 1'b0;
    DATA  = 8'h00;
    repeat (3) @(posedge CLK);
    #1;
    check("reset_state", 64'({PIXEL_VALID, RGB565, X_ADDR, Y_ADDR, WRITE_ADDR, FRAME_DONE}), 64'd0);
    @(negedge CLK);
    RESET = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].vs, vecs[i].h, vecs[i].d);
      @(posedge CLK);
      #1;
      checks++;
      if (PIXEL_VALID !== vecs[i].ev || RGB565 !== vecs[i].rgb || X_ADDR !== vecs[i].x ||
          Y_ADDR !== vecs[i].y || WRITE_ADDR !== vecs[i].a || FRAME_DONE !== vecs[i].done) begin
        errors++;
        $display("FAIL vec[%0d]: got valid=%b rgb=%h x=%0d y=%0d addr=%0d done=%b required valid=%b rgb=%h x=%0d y=%0d addr=%0d done=%b",
                 i, PIXEL_VALID, RGB565, X_ADDR, Y_ADDR, WRITE_ADDR, FRAME_DONE,
                 vecs[i].ev, vecs[i].rgb, vecs[i].x, vecs[i].y, vecs[i].a, vecs[i].done);
      end
    end

    // Oversized frame: 180-pixel lines, 150 lines; only the 176x144 window may be emitted
    sb_en = 1'b1;
    dbyte = 8'h00;
    s0 = strobe_cnt;
    d0 = done_cnt;
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    for (int l = 0; l < 150; l++) send_line(180, l);
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    @(negedge CLK);
    #1;
    check("frame_strobes", 64'(strobe_cnt - s0), 64'd25344);
    check("frame_last_x", 64'(last_x), 64'd175);
    check("frame_last_y", 64'(last_y), 64'd143);
    check("frame_last_addr", 64'(last_a), 64'd25343);
    check("frame_done_count", 64'(done_cnt - d0), 64'd1);
    check("frame_queue_empty", 64'(exp_q.size()), 64'd0);

    // Reset asserted on the low byte of a pixel mid-line
    s0 = strobe_cnt;
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 8'h12);
    push_pix(16'h1234, 0, 0);
    drive(1'b0, 1'b1, 8'h34);
    drive(1'b0, 1'b1, 8'h56);
    @(negedge CLK);
    RESET = 1'b1;
    DATA  = 8'h78;
    @(posedge CLK);
    #1;
    check("reset_midline_outputs",
          64'({PIXEL_VALID, RGB565, X_ADDR, Y_ADDR, WRITE_ADDR, FRAME_DONE}), 64'd0);
    @(negedge CLK);
    RESET = 1'b0;
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 8'(i + 1));
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    @(negedge CLK);
    #1;
    check("no_strobe_after_reset", 64'(strobe_cnt - s0), 64'd1);

    drive(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 8'hAB);
    push_pix(16'hABCD, 0, 0);
    drive(1'b0, 1'b1, 8'hCD);
    drive(1'b0, 1'b1, 8'hEF);
    push_pix(16'hEF01, 1, 0);
    drive(1'b0, 1'b1, 8'h01);
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    @(negedge CLK);
    #1;
    check("restart_strobes", 64'(strobe_cnt - s0), 64'd3);
    check("restart_last_addr", 64'(last_a), 64'd1);
    check("restart_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
